// File: rtl/alu_mc_if.sv
// rtl/alu_mc_if.sv - operand/result handshake bundle for alu_mc
interface alu_mc_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       alu_control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             div_by_zero;

    modport master (
        output in_valid, a, b, alu_control, out_ready,
        input  in_ready, out_valid, result, result_hi, zero, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, alu_control, out_ready,
        output in_ready, out_valid, result, result_hi, zero, div_by_zero
    );
endinterface

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with iterative mul/divu; divider built only with ALU_MC_DIV_EN
module alu_mc #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     reset,
    alu_mc_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef ALU_MC_DIV_EN
        DIV  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic [WIDTH-1:0] alu_out;
    logic [WIDTH:0]   mul_sum;
`ifdef ALU_MC_DIV_EN
    logic [WIDTH:0]   div_shift;
    logic             div_qbit;
`endif

    always_comb begin
        alu_out = '0;
        case (bus.alu_control)
            3'b000:  alu_out = bus.a + bus.b;
            3'b001:  alu_out = bus.a - bus.b;
            3'b010:  alu_out = bus.a & bus.b;
            3'b011:  alu_out = bus.a | bus.b;
            3'b100:  alu_out = WIDTH'(bus.a < bus.b);
            3'b111:  alu_out = WIDTH'($signed(bus.a) < $signed(bus.b));
            default: alu_out = '0;
        endcase
    end

    // {acc, lo} is the running product; lo starts as the multiplier and is consumed LSB first
    assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);

`ifdef ALU_MC_DIV_EN
    // acc is the partial remainder, lo shifts dividend bits out and quotient bits in
    assign div_shift = {acc_q, lo_q[WIDTH-1]};
    assign div_qbit  = (div_shift >= {1'b0, opd_q});
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            opd_q         <= '0;
            acc_q         <= '0;
            lo_q          <= '0;
            result_q      <= '0;
            result_hi_q   <= '0;
            zero_q        <= 1'b1;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            opd_q         <= opd_d;
            acc_q         <= acc_d;
            lo_q          <= lo_d;
            result_q      <= result_d;
            result_hi_q   <= result_hi_d;
            zero_q        <= zero_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        opd_d         = opd_q;
        acc_d         = acc_q;
        lo_d          = lo_q;
        result_d      = result_q;
        result_hi_d   = result_hi_q;
        div_by_zero_d = div_by_zero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    div_by_zero_d = 1'b0;
                    case (bus.alu_control)
                        3'b101: begin
                            state_d = MUL;
                            cnt_d   = CNT_W'(WIDTH);
                            opd_d   = bus.a;
                            acc_d   = '0;
                            lo_d    = bus.b;
                        end
                        3'b110: begin
`ifdef ALU_MC_DIV_EN
                            if (bus.b == '0) begin
                                state_d       = DONE;
                                result_d      = '1;
                                result_hi_d   = bus.a;
                                div_by_zero_d = 1'b1;
                            end else begin
                                state_d = DIV;
                                cnt_d   = CNT_W'(WIDTH);
                                opd_d   = bus.b;
                                acc_d   = '0;
                                lo_d    = bus.a;
                            end
`else
                            state_d       = DONE;
                            result_d      = '0;
                            result_hi_d   = '0;
                            div_by_zero_d = 1'b1;
`endif
                        end
                        default: begin
                            state_d     = DONE;
                            result_d    = alu_out;
                            result_hi_d = '0;
                        end
                    endcase
                end
            end
            MUL: begin
                acc_d = mul_sum[WIDTH:1];
                lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = DONE;
                    result_d    = lo_d;
                    result_hi_d = acc_d;
                end
            end
`ifdef ALU_MC_DIV_EN
            DIV: begin
                acc_d = div_qbit ? (div_shift[WIDTH-1:0] - opd_q) : div_shift[WIDTH-1:0];
                lo_d  = {lo_q[WIDTH-2:0], div_qbit};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = DONE;
                    result_d    = lo_d;
                    result_hi_d = acc_d;
                end
            end
`endif
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        zero_d = (result_d == '0);
    end

    always_comb begin
        bus.in_ready    = (state_q == IDLE);
        bus.out_valid   = (state_q == DONE);
        bus.result      = result_q;
        bus.result_hi   = result_hi_q;
        bus.zero        = zero_q;
        bus.div_by_zero = div_by_zero_q;
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - randomized self-checking bench for alu_mc against an arithmetic model
module tb_alu_mc;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(W)) bus ();
    alu_mc #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t   m;
    logic   m_busy = 1'b0;
    int     m_acc_cyc = 0;
    logic   check_en = 1'b0;

    logic [W-1:0] cap_res, cap_hi;
    logic         cap_zero, cap_dbz;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] prod;
        e.hi  = '0;
        e.dbz = 1'b0;
        e.lat = 1;
        case (op)
            3'd0: e.res = a + b;
            3'd1: e.res = a - b;
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd4: e.res = (a < b) ? 1 : 0;
            3'd5: begin
                prod  = a * b;
                e.res = prod[W-1:0];
                e.hi  = prod[2*W-1:W];
                e.lat = W + 1;
            end
            3'd6: begin
`ifdef ALU_MC_DIV_EN
                if (b == 0) begin
                    e.res = '1;
                    e.hi  = a;
                    e.dbz = 1'b1;
                end else begin
                    e.res = a / b;
                    e.hi  = a % b;
                    e.lat = W + 1;
                end
`else
                e.res = '0;
                e.dbz = 1'b1;
`endif
            end
            default: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
        endcase
        return e;
    endfunction

    // every cycle: handshake flags always, payload while a result is due
    always @(negedge clk) begin
        if (check_en) begin
            chk("in_ready", bus.in_ready, !m_busy || (cyc == m_acc_cyc));
            chk("out_valid", bus.out_valid, m_busy && (cyc >= m_acc_cyc + m.lat));
            if (m_busy && (cyc >= m_acc_cyc + m.lat)) begin
                chk("result", bus.result, m.res);
                chk("result_hi", bus.result_hi, m.hi);
                chk("zero", bus.zero, m.res == 0);
                chk("div_by_zero", bus.div_by_zero, m.dbz);
            end
        end
    end

    task automatic scramble_inputs();
        bus.in_valid    = 1'($urandom_range(0, 1));
        bus.a           = W'($urandom);
        bus.b           = W'($urandom);
        bus.alu_control = 3'($urandom);
    endtask

    task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #1;
        bus.in_valid    = 1'b1;
        bus.alu_control = op;
        bus.a           = a;
        bus.b           = b;
        m         = model(op, a, b);
        m_acc_cyc = cyc;
        m_busy    = 1'b1;
        @(posedge clk); #1;
        scramble_inputs();
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        start_op(op, a, b);
        repeat (m.lat - 1 + hold) begin
            @(posedge clk); #1;
            scramble_inputs();
        end
        cap_res  = bus.result;
        cap_hi   = bus.result_hi;
        cap_zero = bus.zero;
        cap_dbz  = bus.div_by_zero;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        m_busy        = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    task automatic do_reset(input int n);
        check_en     = 1'b0;
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        m_busy       = 1'b0;
        check_en     = 1'b1;
        @(negedge clk);
        chk("rst in_ready", bus.in_ready, 1);
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst result", bus.result, 0);
        chk("rst result_hi", bus.result_hi, 0);
        chk("rst zero", bus.zero, 1);
        chk("rst div_by_zero", bus.div_by_zero, 0);
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.alu_control = '0;
        m = model(3'd0, '0, '0);

        @(posedge clk); #1;
        do_reset(2);

        run_op(3'd0, 16'hFFFF, 16'h0001, 0);
        chk("add wrap result", cap_res, 16'h0000);
        chk("add wrap zero", cap_zero, 1);

        run_op(3'd7, 16'hFFFE, 16'h0003, 1);
        chk("slt result", cap_res, 16'h0001);
        run_op(3'd4, 16'hFFFE, 16'h0003, 0);
        chk("sltu result", cap_res, 16'h0000);
        chk("sltu zero", cap_zero, 1);

        run_op(3'd5, 16'h1234, 16'h0100, 5);
        chk("mul lo", cap_res, 16'h3400);
        chk("mul hi", cap_hi, 16'h0012);

`ifdef ALU_MC_DIV_EN
        run_op(3'd6, 16'd1000, 16'd7, 0);
        chk("divu quot", cap_res, 16'd142);
        chk("divu rem", cap_hi, 16'd6);
        chk("divu dbz", cap_dbz, 0);
        run_op(3'd6, 16'd55, 16'd0, 2);
        chk("div0 quot", cap_res, 16'hFFFF);
        chk("div0 rem", cap_hi, 16'd55);
        chk("div0 dbz", cap_dbz, 1);
`else
        run_op(3'd6, 16'd9, 16'd3, 0);
        chk("nodiv result", cap_res, 16'd0);
        chk("nodiv hi", cap_hi, 16'd0);
        chk("nodiv dbz", cap_dbz, 1);
        chk("nodiv zero", cap_zero, 1);
        run_op(3'd0, 16'd2, 16'd3, 0);
        chk("add after div result", cap_res, 16'd5);
        chk("add after div dbz", cap_dbz, 0);
`endif

        // reset lands in the middle of a multiply
        start_op(3'd5, 16'hFFFF, 16'hFFFF);
        repeat (6) begin
            @(posedge clk); #1;
            scramble_inputs();
        end
        do_reset(1);
        run_op(3'd1, 16'd5, 16'd7, 0);
        chk("sub result", cap_res, 16'hFFFE);

        for (int i = 0; i < 60; i++) begin
            logic [2:0]   op;
            logic [W-1:0] ra, rb;
            op = 3'($urandom);
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: ra = '1;
                2: rb = W'($urandom_range(1, 3));
                default: ;
            endcase
            run_op(op, ra, rb, $urandom_range(0, 3));
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the team's 16-bit combinational ALU, widened to WIDTH bits.
- Adds an iterative unsigned multiply, an iterative unsigned divide/remainder and a signed set-less-than.
- Adds a valid/ready handshake on both the operand and result sides.
- Sits between the register-file read stage and writeback; the control FSM stalls on in_ready/out_valid.

Parameters:
WIDTH  16  operand/result width in bits; legal range 4..64
CNT_W  $clog2(WIDTH+1)  iteration counter width; derived, do not override

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand/opcode valid
in_ready  output  1  block can accept an operation this cycle
a  input  WIDTH  source 1
b  input  WIDTH  source 2
alu_control  input  3  function select
out_valid  output  1  result registers hold a valid result
out_ready  input  1  consumer accepts result this cycle
result  output  WIDTH  primary result
result_hi  output  WIDTH  MUL high half / DIV remainder; 0 for other ops
zero  output  1  result == 0
div_by_zero  output  1  DIV issued with b == 0

Behaviour:
- Opcodes:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 100 sltu (unsigned a<b -> 1 else 0)
  - 101 mul: unsigned, full 2*WIDTH product; low half -> result, high half -> result_hi
  - 110 divu: quotient -> result, remainder -> result_hi
  - 111 slt: signed two's-complement a<b -> 1 else 0
- add/sub wrap modulo 2^WIDTH; no carry/overflow outputs.
- FSM states: IDLE, MUL, DIV, DONE.
- in_ready = (state==IDLE). Accept = in_valid & in_ready; a, b and alu_control are captured on accept.
- IDLE:
  - On accept of opcode 000-100 or 111: compute, register result, go to DONE. out_valid rises the cycle after accept (latency 1).
  - On accept of 101: go to MUL, counter = WIDTH.
  - On accept of 110 with b!=0: go to DIV, counter = WIDTH.
  - On accept of 110 with b==0: go directly to DONE with result = all ones, result_hi = a, div_by_zero = 1 (latency 1).
- MUL: one shift-add step per cycle; the counter decrements each step; on the last step (counter==1) go to DONE. out_valid rises exactly WIDTH+1 cycles after accept.
- DIV: restoring divide, one quotient bit per cycle MSB first, same counting as MUL; out_valid rises WIDTH+1 cycles after accept.
- DONE:
  - out_valid = 1; result, result_hi, zero and div_by_zero are held stable.
  - When out_ready = 1, go to IDLE the next cycle; out_valid drops that cycle.
  - Results are held indefinitely while out_ready = 0.
  - No back-to-back accept in the DONE->IDLE cycle: the minimum issue interval is 2 cycles for single-cycle ops.
- in_valid during MUL/DIV/DONE is ignored; the operands are not captured and in_ready stays low.
- zero reflects the registered result only, never result_hi. It is valid only while out_valid = 1.
- div_by_zero is cleared on the next accept and is 0 for every non-DIV op.
- Reset (any state, including mid-MUL/DIV):
  - Next cycle: state = IDLE, in_ready = 1, out_valid = 0, result = 0, result_hi = 0, zero = 1, div_by_zero = 0.
  - The in-flight operation is discarded.
- in_valid asserted in the same cycle as reset is ignored.

Optional Feature:
- Macro ALU_MC_DIV_EN.
- Defined: the divider and the DIV state are built, and opcode 110 behaves as above.
- Undefined:
  - No divider hardware; the DIV state does not exist.
  - Opcode 110 completes in 1 cycle with result = 0 and result_hi = 0.
  - div_by_zero is asserted to flag the unsupported op; zero = 1.
  - All other opcodes are unchanged.

Test Plan:
- WIDTH=16, reset held 2 cycles then released -> in_ready=1, out_valid=0, result=0, zero=1. Then issue add a=16'hFFFF b=16'h0001 -> out_valid 1 cycle later, result=16'h0000, zero=1.
- slt a=16'hFFFE (-2) b=16'h0003 -> result=1. sltu with the same operands -> result=0, zero=1.
- mul a=16'h1234 b=16'h0100 -> out_valid exactly 17 cycles after accept, result=16'h3400, result_hi=16'h0012. Hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout.
- divu a=16'd1000 b=16'd7 -> after 17 cycles result=142, result_hi=6, div_by_zero=0. divu a=16'd55 b=0 -> after 1 cycle result=16'hFFFF, result_hi=55, div_by_zero=1.
- Start mul a=16'hFFFF b=16'hFFFF, assert reset at cycle 8 -> next cycle state IDLE, out_valid=0, result=0. A subsequent sub a=5 b=7 -> result=16'hFFFE.
- Build without ALU_MC_DIV_EN: issue divu a=9 b=3 -> 1-cycle latency, result=0, result_hi=0, div_by_zero=1. Then issue add 2+3 -> result=5, div_by_zero=0.
